// File: rtl/wb_stage_p.sv
// wb_stage_p: MEM/WB register with load alignment/extension, single-shot write and retire counter
module wb_stage_p #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [2:0]        ctrl_wb,
  input  logic [2:0]        ld_type,
  input  logic [2:0]        byte_off,
  input  logic [XLEN-1:0]   pc4_wb,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [XLEN-1:0]   alu_data,
  input  logic [REG_AW-1:0] rd_wb,
  output logic              op_write,
  output logic [XLEN-1:0]   write_data,
  output logic [REG_AW-1:0] write_addr,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  instret
);
  localparam int OW = (XLEN == 64) ? 3 : 2;
  logic              valid_q, written_q;
  logic [2:0]        ctrl_q, ld_q;
  logic [OW-1:0]     off_q;
  logic [XLEN-1:0]   pc4_q, mem_q, alu_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   sh, top, ext;
  logic signed [XLEN-1:0] sx;
  logic [6:0]        kill;
  logic              ill, bad, mis;
  logic              unused_off;
  assign unused_off = ^byte_off;
  // Extension: push the field to the top, then shift back arithmetically or logically.
  always_comb begin
    sh   = mem_q >> {off_q, 3'b000};
    kill = ld_q[1:0] == 2'b00 ? 7'(XLEN - 8) :
           ld_q[1:0] == 2'b01 ? 7'(XLEN - 16) :
           ld_q[1:0] == 2'b10 ? 7'(XLEN - 32) : 7'd0;
    top  = sh << kill;
    sx   = $signed(top) >>> kill;
    ext  = ld_q[2] ? top >> kill : sx;
    ill  = ld_q == 3'b111 || (XLEN == 32 && (ld_q == 3'b011 || ld_q == 3'b110));
    bad  = (ld_q[1:0] == 2'b01 && off_q[0]) ||
           (ld_q[1:0] == 2'b10 && off_q[1:0] != 2'b00) ||
           (ld_q[1:0] == 2'b11 && off_q != '0);
    mis  = ctrl_q[1] & ~ctrl_q[2] & (ill | bad);
  end
  assign write_data   = ctrl_q[2] ? pc4_q : ctrl_q[1] ? ext : alu_q;
  assign write_addr   = rd_q;
  assign op_write     = valid_q & ctrl_q[0] & (rd_q != '0) & ~mis & ~written_q;
  assign misalign_err = valid_q & mis & ~written_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      written_q <= 1'b0;
      ctrl_q    <= '0;
      ld_q      <= '0;
      off_q     <= '0;
      pc4_q     <= '0;
      mem_q     <= '0;
      alu_q     <= '0;
      rd_q      <= '0;
      instret   <= '0;
    end else begin
      if (flush) begin
        valid_q   <= 1'b0;
        written_q <= 1'b0;
      end else if (stall) begin
        written_q <= written_q | valid_q;
      end else begin
        valid_q   <= in_valid;
        written_q <= 1'b0;
        ctrl_q    <= ctrl_wb;
        ld_q      <= ld_type;
        off_q     <= byte_off[OW-1:0];
        pc4_q     <= pc4_wb;
        mem_q     <= mem_data;
        alu_q     <= alu_data;
        rd_q      <= rd_wb;
      end
      if (valid_q & ~written_q & ~mis) instret <= instret + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_stage_p.sv
// tb_wb_stage_p: directed checks of wb_stage_p at XLEN=32 and XLEN=64
module tb_wb_stage_p;
  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [2:0]  ctrl, lt, off;
  logic [63:0] pc4, mem, alu;
  logic [4:0]  rd;
  logic        ow32, me32, ow64, me64;
  logic [31:0] wd32;
  logic [63:0] wd64, ir32, ir64;
  logic [4:0]  wa32, wa64;
  int n = 0, errs = 0;

  always #5 clk = ~clk;

  wb_stage_p #(.XLEN(32)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl_wb(ctrl), .ld_type(lt), .byte_off(off), .pc4_wb(pc4[31:0]),
    .mem_data(mem[31:0]), .alu_data(alu[31:0]), .rd_wb(rd), .op_write(ow32),
    .write_data(wd32), .write_addr(wa32), .misalign_err(me32), .instret(ir32));

  wb_stage_p #(.XLEN(64)) d64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl_wb(ctrl), .ld_type(lt), .byte_off(off), .pc4_wb(pc4),
    .mem_data(mem), .alu_data(alu), .rd_wb(rd), .op_write(ow64),
    .write_data(wd64), .write_addr(wa64), .misalign_err(me64), .instret(ir64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [2:0] l,
                       input logic [2:0] o, input logic [63:0] p, input logic [63:0] m,
                       input logic [63:0] a, input logic [4:0] r);
    in_valid = v; ctrl = c; lt = l; off = o; pc4 = p; mem = m; alu = a; rd = r;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] mux_exp [8] = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
  logic [2:0]  ld_lt   [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [2:0]  ld_off  [6] = '{3'd0, 3'd3, 3'd3, 3'd2, 3'd2, 3'd0};
  logic [31:0] ld_exp  [6] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                               32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ow", 64'(ow32), 0);
    chk("rst_wd", 64'(wd32), 0);
    chk("rst_wa", 64'(wa32), 0);
    chk("rst_me", 64'(me32), 0);
    chk("rst_ir", ir32, 0);
    chk("rst_wd64", wd64, 0);
    rst = 1'b0;
    // legacy mux
    for (int c = 0; c < 8; c++) begin
      drive(1, 3'(c), 3'b010, 0, 64'd3, 64'd2, 64'd1, 5'd4);
      tick();
      chk($sformatf("mux_wd%0d", c), 64'(wd32), 64'(mux_exp[c]));
      chk($sformatf("mux_ow%0d", c), 64'(ow32), 64'(c & 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mux_ir", ir32, 64'd8);
    // load extension
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'b011, ld_lt[i], ld_off[i], 0, 64'h80FF7F01, 0, 5'd5);
      tick();
      chk($sformatf("ld_wd%0d", i), 64'(wd32), 64'(ld_exp[i]));
      chk($sformatf("ld_ow%0d", i), 64'(ow32), 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ld_ir", ir32, 64'd14);
    // misalignment
    drive(1, 3'b011, 3'b001, 3'd1, 0, 64'h80FF7F01, 0, 5'd5);
    tick();
    chk("mis_lh_ow", 64'(ow32), 0);
    chk("mis_lh_me", 64'(me32), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mis_lh_pulse", 64'(me32), 0);
    chk("mis_lh_ir", ir32, 64'd14);
    drive(1, 3'b011, 3'b010, 3'd2, 0, 64'h80FF7F01, 0, 5'd5);
    tick();
    chk("mis_lw_ow", 64'(ow32), 0);
    chk("mis_lw_me", 64'(me32), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mis_lw_pulse", 64'(me32), 0);
    chk("mis_lw_ir", ir32, 64'd14);
    // x0 suppression
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'h77, 5'd0);
    tick();
    chk("x0_ow", 64'(ow32), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("x0_ir", ir32, 64'd15);
    // stall: single-shot write, held data, flush in second stall cycle
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'h55, 5'd7);
    tick();
    chk("st_ow0", 64'(ow32), 1);
    chk("st_wd0", 64'(wd32), 64'h55);
    stall = 1'b1;
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'h99, 5'd9);
    tick();
    chk("st_ow1", 64'(ow32), 0);
    chk("st_wd1", 64'(wd32), 64'h55);
    chk("st_wa1", 64'(wa32), 64'd7);
    chk("st_ir1", ir32, 64'd16);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("st_ow2", 64'(ow32), 0);
    chk("st_ir2", ir32, 64'd16);
    tick();
    chk("st_ow3", 64'(ow32), 0);
    chk("st_ir3", ir32, 64'd16);
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("st_ir4", ir32, 64'd16);
    // flush still lets the instruction on the outputs retire
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'h66, 5'd3);
    tick();
    chk("fl_ow0", 64'(ow32), 1);
    flush = 1'b1;
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'hAA, 5'd4);
    tick();
    flush = 1'b0;
    chk("fl_ow1", 64'(ow32), 0);
    chk("fl_ir1", ir32, 64'd17);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("fl_ir2", ir32, 64'd17);
    // reset mid-stream
    drive(1, 3'b001, 3'b010, 0, 0, 0, 64'h1234, 5'd9);
    tick();
    chk("rm_ow0", 64'(ow32), 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("rm_ow", 64'(ow32), 0);
    chk("rm_wd", 64'(wd32), 0);
    chk("rm_wa", 64'(wa32), 0);
    chk("rm_ir", ir32, 0);
    chk("rm_ir64", ir64, 0);
    // XLEN=64 loads
    drive(1, 3'b011, 3'b011, 3'd0, 0, 64'hF0DEBC9A87654321, 0, 5'd10);
    tick();
    chk("x64_ld_wd", wd64, 64'hF0DEBC9A87654321);
    chk("x64_ld_ow", 64'(ow64), 1);
    chk("x32_ld_me", 64'(me32), 1);
    drive(1, 3'b011, 3'b110, 3'd4, 0, 64'hF0DEBC9A87654321, 0, 5'd10);
    tick();
    chk("x64_lwu_wd", wd64, 64'h00000000F0DEBC9A);
    chk("x32_lwu_me", 64'(me32), 1);
    drive(1, 3'b011, 3'b010, 3'd4, 0, 64'hF0DEBC9A87654321, 0, 5'd10);
    tick();
    chk("x64_lw_wd", wd64, 64'hFFFFFFFFF0DEBC9A);
    chk("x32_lw_wd", 64'(wd32), 64'h87654321);
    drive(1, 3'b011, 3'b011, 3'd4, 0, 64'hF0DEBC9A87654321, 0, 5'd10);
    tick();
    chk("x64_ld4_me", 64'(me64), 1);
    chk("x64_ld4_ow", 64'(ow64), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("x64_ir", ir64, 64'd3);
    chk("x32_ir", ir32, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
